// File: rtl/gate_sensor_decoder.sv
// Gate lane front end: synchronises and debounces the two IR beams, then decodes
// the A/B crossing order into single-cycle car_enter / car_exit / fault pulses.
module gate_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic       car_enter,
    output logic       car_exit,
    output logic       gate_busy,
    output logic       fault,
    output logic [2:0] dbg_state_o
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_A     = 3'd1,
        IN_AB    = 3'd2,
        IN_B     = 3'd3,
        OUT_B    = 3'd4,
        OUT_BA   = 3'd5,
        OUT_A    = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    // Bit 0 carries beam A, bit 1 carries beam B through sync and debounce.
    logic [1:0]      meta_q;
    logic [1:0]      sync_q;
    logic [1:0]      filt_q;
    logic [DB_W-1:0] db_cnt_q [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            filt_q   <= '0;
            db_cnt_q <= '{default: '0};
        end else begin
            meta_q <= {sensor_b, sensor_a};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    filt_q[i]   <= sync_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             enter_q, enter_d;
    logic             exit_q, exit_d;
    logic             fault_q, fault_d;
    logic [1:0]       ab;

    assign ab = {filt_q[0], filt_q[1]};

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        fault_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ab == 2'b10) state_d = IN_A;
                else if (ab == 2'b01) state_d = OUT_B;
                else if (ab == 2'b11) state_d = WAIT_CLR;
            end
            IN_A: begin
                if (ab == 2'b11) state_d = IN_AB;
                else if (ab == 2'b00) state_d = IDLE;
                else if (ab == 2'b01) state_d = WAIT_CLR;
            end
            IN_AB: begin
                if (ab == 2'b01) state_d = IN_B;
                else if (ab == 2'b10) state_d = IN_A;
                else if (ab == 2'b00) state_d = WAIT_CLR;
            end
            IN_B: begin
                if (ab == 2'b00) begin
                    state_d = IDLE;
                    enter_d = 1'b1;
                end else if (ab == 2'b11) state_d = IN_AB;
                else if (ab == 2'b10) state_d = WAIT_CLR;
            end
            OUT_B: begin
                if (ab == 2'b11) state_d = OUT_BA;
                else if (ab == 2'b00) state_d = IDLE;
                else if (ab == 2'b10) state_d = WAIT_CLR;
            end
            OUT_BA: begin
                if (ab == 2'b10) state_d = OUT_A;
                else if (ab == 2'b01) state_d = OUT_B;
                else if (ab == 2'b00) state_d = WAIT_CLR;
            end
            OUT_A: begin
                if (ab == 2'b00) begin
                    state_d = IDLE;
                    exit_d  = 1'b1;
                end else if (ab == 2'b11) state_d = OUT_BA;
                else if (ab == 2'b01) state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (ab == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The timeout spans the whole crossing and wins over any sensor move this cycle.
        if (state_q == IDLE || state_q == WAIT_CLR) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
                state_d = WAIT_CLR;
                enter_d = 1'b0;
                exit_d  = 1'b0;
            end
        end

        fault_d = (state_d == WAIT_CLR) && (state_q != WAIT_CLR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            fault_q <= fault_d;
        end
    end

    assign car_enter   = enter_q;
    assign car_exit    = exit_q;
    assign fault       = fault_q;
    assign gate_busy   = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder: crossings, bounce, back-outs, illegal
// sequences, timeout and mid-crossing reset, each checked against hand-derived cycles.
module tb_gate_sensor_decoder;

    logic       clk;
    logic       reset;
    logic       sensor_a;
    logic       sensor_b;
    logic       car_enter;
    logic       car_exit;
    logic       gate_busy;
    logic       fault;
    logic [2:0] dbg_state_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int enter_seen = 0;
    int exit_seen = 0;
    int fault_seen = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_IN_A = 3'd1, S_IN_AB = 3'd2, S_IN_B = 3'd3;
    localparam logic [2:0] S_OUT_B = 3'd4, S_WAIT = 3'd7;

    gate_sensor_decoder #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor_a   (sensor_a),
        .sensor_b   (sensor_b),
        .car_enter  (car_enter),
        .car_exit   (car_exit),
        .gate_busy  (gate_busy),
        .fault      (fault),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and enter/exit exclusivity, sampled mid-cycle.
    always @(negedge clk) begin
        if (car_enter) enter_seen++;
        if (car_exit) exit_seen++;
        if (fault) fault_seen++;
        vec_cnt++;
        if (car_enter && car_exit) begin
            err_cnt++;
            $display("FAIL exclusive: car_enter=%b car_exit=%b both high at %0t", car_enter, car_exit, $time);
        end
    end

    // Driver tasks: inputs change only right after a falling edge.
    task automatic drive(input logic a, input logic b);
        sensor_a = a;
        sensor_b = b;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0);
        cycles(3);
        vec_cnt += 5;
        if (gate_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", gate_busy); end
        if (car_enter !== 1'b0) begin err_cnt++; $display("FAIL reset_enter: got %b want 0", car_enter); end
        if (car_exit !== 1'b0) begin err_cnt++; $display("FAIL reset_exit: got %b want 0", car_exit); end
        if (fault !== 1'b0) begin err_cnt++; $display("FAIL reset_fault: got %b want 0", fault); end
        if (dbg_state_o !== S_IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d want %0d", dbg_state_o, S_IDLE); end
        reset = 1'b0;
        cycles(2);
    endtask

    task automatic test_entry;
        int e0, x0, f0;
        logic exp;
        e0 = enter_seen; x0 = exit_seen; f0 = fault_seen;
        drive(1'b1, 1'b0); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IN_A) begin err_cnt++; $display("FAIL entry_in_a: got %0d want %0d", dbg_state_o, S_IN_A); end
        drive(1'b1, 1'b1); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IN_AB) begin err_cnt++; $display("FAIL entry_in_ab: got %0d want %0d", dbg_state_o, S_IN_AB); end
        drive(1'b0, 1'b1); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IN_B) begin err_cnt++; $display("FAIL entry_in_b: got %0d want %0d", dbg_state_o, S_IN_B); end
        drive(1'b0, 1'b0);
        // Falling edge of b: sampled at the 1st rising edge, filtered at the 6th, pulse after the 7th.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k == 7);
            vec_cnt++;
            if (car_enter !== exp) begin err_cnt++; $display("FAIL entry_pulse k=%0d: got %b want %b", k, car_enter, exp); end
        end
        vec_cnt += 4;
        if (enter_seen - e0 != 1) begin err_cnt++; $display("FAIL entry_count: got %0d want 1", enter_seen - e0); end
        if (exit_seen - x0 != 0) begin err_cnt++; $display("FAIL entry_no_exit: got %0d want 0", exit_seen - x0); end
        if (fault_seen - f0 != 0) begin err_cnt++; $display("FAIL entry_no_fault: got %0d want 0", fault_seen - f0); end
        if (gate_busy !== 1'b0) begin err_cnt++; $display("FAIL entry_idle: busy got %b want 0", gate_busy); end
    endtask

    task automatic test_exit;
        int e0, x0, f0;
        logic exp;
        e0 = enter_seen; x0 = exit_seen; f0 = fault_seen;
        drive(1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = (k >= 7);
            vec_cnt++;
            if (gate_busy !== exp) begin err_cnt++; $display("FAIL exit_busy_rise k=%0d: got %b want %b", k, gate_busy, exp); end
        end
        vec_cnt++;
        if (dbg_state_o !== S_OUT_B) begin err_cnt++; $display("FAIL exit_out_b: got %0d want %0d", dbg_state_o, S_OUT_B); end
        drive(1'b1, 1'b1); cycles(10);
        drive(1'b1, 1'b0); cycles(10);
        drive(1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = (k == 7);
            vec_cnt += 2;
            if (car_exit !== exp) begin err_cnt++; $display("FAIL exit_pulse k=%0d: got %b want %b", k, car_exit, exp); end
            if (gate_busy !== (k < 7)) begin err_cnt++; $display("FAIL exit_busy_fall k=%0d: got %b want %b", k, gate_busy, (k < 7)); end
        end
        vec_cnt += 3;
        if (exit_seen - x0 != 1) begin err_cnt++; $display("FAIL exit_count: got %0d want 1", exit_seen - x0); end
        if (enter_seen - e0 != 0) begin err_cnt++; $display("FAIL exit_no_enter: got %0d want 0", enter_seen - e0); end
        if (fault_seen - f0 != 0) begin err_cnt++; $display("FAIL exit_no_fault: got %0d want 0", fault_seen - f0); end
    endtask

    task automatic test_bounce;
        int e0, x0, f0;
        e0 = enter_seen; x0 = exit_seen; f0 = fault_seen;
        drive(1'b1, 1'b0); cycles(1);
        drive(1'b0, 1'b0); cycles(3);
        drive(1'b0, 1'b1); cycles(1);
        drive(1'b0, 1'b0); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IDLE) begin err_cnt++; $display("FAIL bounce_idle: got %0d want %0d", dbg_state_o, S_IDLE); end
        drive(1'b1, 1'b0); cycles(10);
        drive(1'b1, 1'b1); cycles(10);
        drive(1'b0, 1'b1); cycles(3);
        drive(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            vec_cnt++;
            if (dbg_state_o !== S_IN_AB) begin err_cnt++; $display("FAIL bounce_in_ab k=%0d: got %0d want %0d", k, dbg_state_o, S_IN_AB); end
        end
        vec_cnt += 2;
        if (enter_seen - e0 != 0) begin err_cnt++; $display("FAIL bounce_no_enter: got %0d want 0", enter_seen - e0); end
        if (fault_seen - f0 != 0) begin err_cnt++; $display("FAIL bounce_no_fault: got %0d want 0", fault_seen - f0); end
        drive(1'b0, 1'b1); cycles(10);
        drive(1'b0, 1'b0); cycles(10);
        vec_cnt += 2;
        if (enter_seen - e0 != 1) begin err_cnt++; $display("FAIL bounce_finish: got %0d want 1", enter_seen - e0); end
        if (exit_seen - x0 != 0) begin err_cnt++; $display("FAIL bounce_no_exit: got %0d want 0", exit_seen - x0); end
    endtask

    task automatic test_backout;
        int e0, x0, f0;
        e0 = enter_seen; x0 = exit_seen; f0 = fault_seen;
        drive(1'b1, 1'b0); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IN_A) begin err_cnt++; $display("FAIL backout_in_a: got %0d want %0d", dbg_state_o, S_IN_A); end
        drive(1'b0, 1'b0); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IDLE) begin err_cnt++; $display("FAIL backout_idle: got %0d want %0d", dbg_state_o, S_IDLE); end
        drive(1'b1, 1'b0); cycles(10);
        drive(1'b1, 1'b1); cycles(10);
        drive(1'b1, 1'b0); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IN_A) begin err_cnt++; $display("FAIL reverse_in_a: got %0d want %0d", dbg_state_o, S_IN_A); end
        drive(1'b0, 1'b0); cycles(10);
        vec_cnt += 4;
        if (dbg_state_o !== S_IDLE) begin err_cnt++; $display("FAIL reverse_idle: got %0d want %0d", dbg_state_o, S_IDLE); end
        if (enter_seen - e0 != 0) begin err_cnt++; $display("FAIL backout_no_enter: got %0d want 0", enter_seen - e0); end
        if (exit_seen - x0 != 0) begin err_cnt++; $display("FAIL backout_no_exit: got %0d want 0", exit_seen - x0); end
        if (fault_seen - f0 != 0) begin err_cnt++; $display("FAIL backout_no_fault: got %0d want 0", fault_seen - f0); end
    endtask

    task automatic test_illegal;
        int f0;
        logic exp;
        f0 = fault_seen;
        drive(1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k == 7);
            vec_cnt++;
            if (fault !== exp) begin err_cnt++; $display("FAIL illegal_fault k=%0d: got %b want %b", k, fault, exp); end
        end
        cycles(10);
        vec_cnt += 2;
        if (dbg_state_o !== S_WAIT) begin err_cnt++; $display("FAIL illegal_wait: got %0d want %0d", dbg_state_o, S_WAIT); end
        if (fault_seen - f0 != 1) begin err_cnt++; $display("FAIL illegal_count: got %0d want 1", fault_seen - f0); end
        drive(1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = (k < 7);
            vec_cnt++;
            if (gate_busy !== exp) begin err_cnt++; $display("FAIL illegal_clear k=%0d: got %b want %b", k, gate_busy, exp); end
        end
    endtask

    task automatic test_timeout;
        int e0, x0, f0;
        logic exp;
        e0 = enter_seen; x0 = exit_seen; f0 = fault_seen;
        drive(1'b1, 1'b0);
        // IN_A is entered after the 7th rising edge; 64 busy cycles later the fault fires.
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            exp = (k == 71);
            vec_cnt++;
            if (fault !== exp) begin err_cnt++; $display("FAIL timeout_fault k=%0d: got %b want %b", k, fault, exp); end
        end
        vec_cnt++;
        if (dbg_state_o !== S_WAIT) begin err_cnt++; $display("FAIL timeout_wait: got %0d want %0d", dbg_state_o, S_WAIT); end
        drive(1'b0, 1'b0); cycles(10);
        vec_cnt += 4;
        if (gate_busy !== 1'b0) begin err_cnt++; $display("FAIL timeout_idle: got %b want 0", gate_busy); end
        if (fault_seen - f0 != 1) begin err_cnt++; $display("FAIL timeout_count: got %0d want 1", fault_seen - f0); end
        if (enter_seen - e0 != 0) begin err_cnt++; $display("FAIL timeout_no_enter: got %0d want 0", enter_seen - e0); end
        if (exit_seen - x0 != 0) begin err_cnt++; $display("FAIL timeout_no_exit: got %0d want 0", exit_seen - x0); end
    endtask

    task automatic test_reset_mid;
        int e0;
        e0 = enter_seen;
        drive(1'b1, 1'b0); cycles(10);
        drive(1'b1, 1'b1); cycles(10);
        drive(1'b0, 1'b1); cycles(10);
        vec_cnt++;
        if (dbg_state_o !== S_IN_B) begin err_cnt++; $display("FAIL rstmid_in_b: got %0d want %0d", dbg_state_o, S_IN_B); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            vec_cnt += 4;
            if (gate_busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy k=%0d: got %b want 0", k, gate_busy); end
            if (car_enter !== 1'b0) begin err_cnt++; $display("FAIL rstmid_enter k=%0d: got %b want 0", k, car_enter); end
            if (fault !== 1'b0) begin err_cnt++; $display("FAIL rstmid_fault k=%0d: got %b want 0", k, fault); end
            if (dbg_state_o !== S_IDLE) begin err_cnt++; $display("FAIL rstmid_state k=%0d: got %0d want %0d", k, dbg_state_o, S_IDLE); end
            @(negedge clk);
        end
        cycles(20);
        vec_cnt++;
        if (enter_seen - e0 != 0) begin err_cnt++; $display("FAIL rstmid_no_enter: got %0d want 0", enter_seen - e0); end
    endtask

    initial begin
        reset    = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        @(negedge clk);
        test_reset;
        test_entry;
        test_exit;
        test_bounce;
        test_backout;
        test_illegal;
        test_timeout;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
